// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param_if
// Description : Serial line in, received word out on a valid/ready handshake,
//               plus the per-word error flags and receiver status.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;

  // Receiver side: owns the word stream.
  modport master (
    input  rxd,
    input  data_ready,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output overrun_err,
    output busy
  );

  // Line driver / word consumer side.
  modport slave (
    output rxd,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  overrun_err,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver, mid-bit sampling, optional parity,
//               1/2 stop bits, valid/ready word output with error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_param_if.master rx
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] DATA_END = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_END = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchroniser and edge detector
  logic sync1_q, sync1_d;
  logic rxs_q, rxs_d;
  logic rxs_prev_q, rxs_prev_d;

  // Frame engine
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic                 done_q, done_d;

  // Output word register
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic                 fall;
  logic                 bit_mid;
  logic                 par_bad;
  logic                 accept;
  logic [DATA_BITS-1:0] shift_in;

  // Shift direction decides which end of the word the first bit lands in.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_in = {shift_q[DATA_BITS-2:0], rxs_q};
    end else begin : g_lsb_first
      assign shift_in = {rxs_q, shift_q[DATA_BITS-1:1]};
    end
  endgenerate

  assign fall    = rxs_prev_q & ~rxs_q;
  assign bit_mid = (cnt_q == BIT_END);
  assign par_bad = ((^shift_q) ^ rxs_q) != (PARITY_ODD != 0);
  assign accept  = data_valid_q & rx.data_ready;

  always_comb begin
    sync1_d     = rx.rxd;
    rxs_d       = sync1_q;
    rxs_prev_d  = rxs_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DATA;
            perr_pend_d = 1'b0;
            ferr_pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_mid) begin
          cnt_d   = '0;
          shift_d = shift_in;
          if (bit_cnt_q == DATA_END) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_mid) begin
          cnt_d       = '0;
          perr_pend_d = par_bad;
          state_d     = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_mid) begin
          cnt_d = '0;
          if (!rxs_q) begin
            ferr_pend_d = 1'b1;
          end
          if (bit_cnt_q == STOP_END) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A completed frame loads only into a free (or just-freed) output slot.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (accept) begin
      data_valid_d = 1'b0;
    end

    if (done_q) begin
      if (!data_valid_q || accept) begin
        data_out_d   = shift_q;
        parity_err_d = perr_pend_q;
        frame_err_d  = ferr_pend_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      rxs_q        <= rxs_d;
      rxs_prev_q   <= rxs_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx.data_out    = data_out_q;
  assign rx.data_valid  = data_valid_q;
  assign rx.parity_err  = parity_err_q;
  assign rx.frame_err   = frame_err_q;
  assign rx.overrun_err = overrun_q;
  assign rx.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
